fpu_addsub_pipe_ctrl: RTL and testbench

FPU_ADDSUB_PIPE_CTRL -- requirements
Module: fpu_addsub_pipe_ctrl

---
 rtl/fpu_addsub_pipe_ctrl.sv | 166 ++++++++++++++++
 tb/tb_fpu_addsub_pipe_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_pipe_ctrl.sv
// fpu_addsub_pipe_ctrl: multi-cycle IEEE-754 add/subtract, subnormals flushed to zero
//   clk, rst (asynchronous, active-low)
//   in_valid/in_ready   : accept Data_X, Data_Y, add_subt (0 add, 1 sub), r_mode
//   out_valid/out_ready : deliver final_result_ieee with overflow/underflow/invalid flags
//   Macro FPU_ADDSUB_INEXACT_EN adds the inexact_flag output.
module fpu_addsub_pipe_ctrl #(
   parameter int W  = 32,
   parameter int EW = 8,
   parameter int SW = 23
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  Data_X,
   input  logic [W-1:0]  Data_Y,
   input  logic          add_subt,
   input  logic [1:0]    r_mode,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  final_result_ieee,
   output logic          overflow_flag,
   output logic          underflow_flag,
   output logic          invalid_flag
`ifdef FPU_ADDSUB_INEXACT_EN
   ,
   output logic          inexact_flag
`endif
);
   localparam int MW = SW + 4;
   localparam logic [EW-1:0] EMAX = '1;
   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
   state_t state_q;
   logic ready_q, valid_q, of_q, uf_q, inv_q, op_q, sub_q, s_q, zs_q, spec_q, spec_inv_q, nz_q;
   logic [1:0] rm_q;
   logic [W-1:0] x_q, y_q, res_q, spec_res_q;
   logic [EW-1:0] e_q;
   logic [MW-1:0] mb_q, ms_q, nm_q;
   logic [MW:0] sum_q;
   logic signed [EW+1:0] ne_q;
`ifdef FPU_ADDSUB_INEXACT_EN
   logic inx_q;
`endif
   // Unpack and align; significands are {hidden, fraction, guard, round, sticky}
   logic [EW-1:0] ex, ey, eb, d;
   logic [SW-1:0] fx, fy;
   logic sx, sy, xz, yz, xn, yn, xi, yi, xb;
   logic [MW-1:0] mx, my, mb_d, msr, ms_d;
   logic [2*MW-1:0] sh;
   logic [W-1:0] spec_res_d;
   always_comb begin
      sx = x_q[W-1];
      sy = y_q[W-1] ^ op_q;
      ex = x_q[W-2:SW];
      ey = y_q[W-2:SW];
      fx = x_q[SW-1:0];
      fy = y_q[SW-1:0];
      xz = ex == '0;
      yz = ey == '0;
      xn = ex == EMAX && fx != '0;
      yn = ey == EMAX && fy != '0;
      xi = ex == EMAX && fx == '0;
      yi = ey == EMAX && fy == '0;
      mx = xz ? '0 : {1'b1, fx, 3'b000};
      my = yz ? '0 : {1'b1, fy, 3'b000};
      xb = (xz ? '0 : x_q[W-2:0]) >= (yz ? '0 : y_q[W-2:0]);
      mb_d = xb ? mx : my;
      msr = xb ? my : mx;
      eb = xb ? ex : ey;
      d = eb - (xb ? ey : ex);
      sh = {msr, {MW{1'b0}}} >> d;
      ms_d = int'(d) >= SW + 3 ? {{(MW-1){1'b0}}, |msr} : {sh[2*MW-1:MW+1], sh[MW] | (|sh[MW-1:0])};
      spec_res_d = (xn | yn | (xi & yi & (sx ^ sy))) ? {1'b0, EMAX, 1'b1, {(SW-1){1'b0}}} : {xi ? sx : sy, EMAX, {SW{1'b0}}};
   end
   // Normalise: right by one on carry-out, otherwise left by the leading-zero count
   int lz;
   logic [MW-1:0] nm_d;
   logic signed [EW+1:0] ne_d;
   always_comb begin
      lz = MW;
      for (int i = 0; i < MW; i++) if (sum_q[i]) lz = MW - 1 - i;
      nm_d = sum_q[MW] ? {sum_q[MW:2], |sum_q[1:0]} : sum_q[MW-1:0] << lz;
      ne_d = (EW+2)'(int'(e_q) + int'(sum_q[MW]) - lz);
   end
   // Round and pack
   logic g, r, st, inx, inc, rc, of_d, uf_d, to_inf;
   logic [SW+1:0] rsum;
   logic signed [EW+1:0] re;
   logic [W-1:0] res_d;
   always_comb begin
      {g, r, st} = nm_q[2:0];
      inx = g | r | st;
      inc = rm_q == 2'b00 ? g & (r | st | nm_q[3]) : rm_q == 2'b01 ? ~s_q & inx : rm_q == 2'b10 ? s_q & inx : 1'b0;
      rsum = {1'b0, nm_q[MW-1:3]} + (SW+2)'(inc);
      rc = rsum[SW+1];
      re = ne_q + (EW+2)'(rc);
      uf_d = !spec_q && !nz_q && (ne_q[EW+1] || ne_q == '0);
      of_d = !spec_q && !nz_q && !uf_d && re >= $signed({2'b00, EMAX});
      to_inf = rm_q == 2'b00 || (rm_q == 2'b01 && !s_q) || (rm_q == 2'b10 && s_q);
      res_d = spec_q ? spec_res_q : nz_q ? {zs_q, {(W-1){1'b0}}} : uf_d ? {s_q, {(W-1){1'b0}}} :
              of_d ? (to_inf ? {s_q, EMAX, {SW{1'b0}}} : {s_q, EMAX - 1'b1, {SW{1'b1}}}) :
              {s_q, re[EW-1:0], rc ? rsum[SW:1] : rsum[SW-1:0]};
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE; ready_q <= 1'b0; valid_q <= 1'b0; res_q <= '0;
         of_q <= 1'b0; uf_q <= 1'b0; inv_q <= 1'b0; op_q <= 1'b0; rm_q <= '0;
         x_q <= '0; y_q <= '0; sub_q <= 1'b0; s_q <= 1'b0; zs_q <= 1'b0;
         spec_q <= 1'b0; spec_inv_q <= 1'b0; spec_res_q <= '0; e_q <= '0;
         mb_q <= '0; ms_q <= '0; sum_q <= '0; nm_q <= '0; ne_q <= '0; nz_q <= 1'b0;
`ifdef FPU_ADDSUB_INEXACT_EN
         inx_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: if (in_valid && ready_q) begin
               x_q <= Data_X; y_q <= Data_Y; op_q <= add_subt; rm_q <= r_mode;
               of_q <= 1'b0; uf_q <= 1'b0; inv_q <= 1'b0; ready_q <= 1'b0;
`ifdef FPU_ADDSUB_INEXACT_EN
               inx_q <= 1'b0;
`endif
               state_q <= ALIGN;
            end else ready_q <= 1'b1;
            ALIGN: begin
               mb_q <= mb_d; ms_q <= ms_d; e_q <= eb; s_q <= xb ? sx : sy;
               sub_q <= sx ^ sy;
               // exact-zero sign: common sign if both agree, else -0 only when rounding down
               zs_q <= sx == sy ? sx : rm_q == 2'b10;
               spec_q <= xn | yn | xi | yi;
               spec_inv_q <= (xn & ~fx[SW-1]) | (yn & ~fy[SW-1]) | (xi & yi & (sx ^ sy));
               spec_res_q <= spec_res_d;
               state_q <= ADD;
            end
            ADD: begin
               sum_q <= sub_q ? {1'b0, mb_q} - {1'b0, ms_q} : {1'b0, mb_q} + {1'b0, ms_q};
               state_q <= NORM;
            end
            NORM: begin
               nm_q <= nm_d; ne_q <= ne_d; nz_q <= sum_q == '0;
               state_q <= ROUND;
            end
            ROUND: begin
               res_q <= res_d; of_q <= of_d; uf_q <= uf_d; inv_q <= spec_q & spec_inv_q;
`ifdef FPU_ADDSUB_INEXACT_EN
               inx_q <= of_d | uf_d | (!spec_q & !nz_q & inx);
`endif
               state_q <= DONE;
            end
            DONE: if (!valid_q) valid_q <= 1'b1;
            else if (out_ready) begin
               valid_q <= 1'b0; ready_q <= 1'b1; state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign in_ready = ready_q;
   assign out_valid = valid_q;
   assign final_result_ieee = res_q;
   assign overflow_flag = of_q;
   assign underflow_flag = uf_q;
   assign invalid_flag = inv_q;
`ifdef FPU_ADDSUB_INEXACT_EN
   assign inexact_flag = inx_q;
`endif
endmodule

// File: tb/tb_fpu_addsub_pipe_ctrl.sv
// tb_fpu_addsub_pipe_ctrl: directed vector bench for fpu_addsub_pipe_ctrl (W=32)
module tb_fpu_addsub_pipe_ctrl;
   logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, add_subt = 1'b0, out_ready = 1'b0;
   logic [1:0] r_mode = 2'b00;
   logic [31:0] Data_X = '0, Data_Y = '0, final_result_ieee;
   logic in_ready, out_valid, overflow_flag, underflow_flag, invalid_flag;
`ifdef FPU_ADDSUB_INEXACT_EN
   logic inexact_flag;
`endif
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   fpu_addsub_pipe_ctrl dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .Data_X(Data_X), .Data_Y(Data_Y), .add_subt(add_subt), .r_mode(r_mode),
      .out_valid(out_valid), .out_ready(out_ready), .final_result_ieee(final_result_ieee),
      .overflow_flag(overflow_flag), .underflow_flag(underflow_flag), .invalid_flag(invalid_flag)
`ifdef FPU_ADDSUB_INEXACT_EN
      , .inexact_flag(inexact_flag)
`endif
   );
   typedef struct {
      logic [31:0] x, y;
      logic op;
      logic [1:0] rm;
      logic [31:0] res;
      logic of, uf, inv, inx;
   } vec_t;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic op, input logic [1:0] rm, output int lat);
      int n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_before_accept", 32'(in_ready), 32'd1);
      @(negedge clk);
      Data_X = x; Data_Y = y; add_subt = op; r_mode = rm; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask
   task automatic finish_op;
      @(negedge clk) out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("out_valid_drop", 32'(out_valid), 32'd0);
   endtask
   task automatic check_vec(input string tag, input vec_t v, input int lat);
      chk({tag, "_latency"}, 32'(lat), 32'd5);
      chk({tag, "_result"}, final_result_ieee, v.res);
      chk({tag, "_overflow"}, 32'(overflow_flag), 32'(v.of));
      chk({tag, "_underflow"}, 32'(underflow_flag), 32'(v.uf));
      chk({tag, "_invalid"}, 32'(invalid_flag), 32'(v.inv));
`ifdef FPU_ADDSUB_INEXACT_EN
      chk({tag, "_inexact"}, 32'(inexact_flag), 32'(v.inx));
`endif
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   initial begin
      vec_t v [24];
      int lat;
      logic seen;
      //        x             y             op    rm     result        of    uf    inv   inx
      v[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 2'd0, 32'h40400000, 1'b0, 1'b0, 1'b0, 1'b0};
      v[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 2'd0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0};
      v[2]  = '{32'h3F800000, 32'h3F800000, 1'b1, 2'd2, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0};
      v[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'd0, 32'h7F800000, 1'b1, 1'b0, 1'b0, 1'b1};
      v[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'd3, 32'h7F7FFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
      v[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'd1, 32'h7F800000, 1'b1, 1'b0, 1'b0, 1'b1};
      v[6]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'd2, 32'h7F7FFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
      v[7]  = '{32'h7F800000, 32'hFF800000, 1'b0, 2'd0, 32'h7FC00000, 1'b0, 1'b0, 1'b1, 1'b0};
      v[8]  = '{32'h3F800000, 32'h33800000, 1'b0, 2'd0, 32'h3F800000, 1'b0, 1'b0, 1'b0, 1'b1};
      v[9]  = '{32'h3F800000, 32'h33800000, 1'b0, 2'd1, 32'h3F800001, 1'b0, 1'b0, 1'b0, 1'b1};
      v[10] = '{32'h7F800000, 32'h3F800000, 1'b0, 2'd0, 32'h7F800000, 1'b0, 1'b0, 1'b0, 1'b0};
      v[11] = '{32'h7FC00000, 32'h3F800000, 1'b0, 2'd0, 32'h7FC00000, 1'b0, 1'b0, 1'b0, 1'b0};
      v[12] = '{32'h7F800001, 32'h00000000, 1'b0, 2'd0, 32'h7FC00000, 1'b0, 1'b0, 1'b1, 1'b0};
      v[13] = '{32'h80000000, 32'h80000000, 1'b0, 2'd0, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0};
      v[14] = '{32'h00400000, 32'h80000000, 1'b0, 2'd0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0};
      v[15] = '{32'h00800000, 32'h00800001, 1'b1, 2'd0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
      v[16] = '{32'h40400000, 32'h3F800000, 1'b1, 2'd0, 32'h40000000, 1'b0, 1'b0, 1'b0, 1'b0};
      v[17] = '{32'hC0000000, 32'h3F800000, 1'b0, 2'd0, 32'hBF800000, 1'b0, 1'b0, 1'b0, 1'b0};
      v[18] = '{32'h3F800000, 32'h00800000, 1'b0, 2'd1, 32'h3F800001, 1'b0, 1'b0, 1'b0, 1'b1};
      v[19] = '{32'h3F800000, 32'h00800000, 1'b0, 2'd2, 32'h3F800000, 1'b0, 1'b0, 1'b0, 1'b1};
      v[20] = '{32'h3F800001, 32'h33800000, 1'b0, 2'd0, 32'h3F800002, 1'b0, 1'b0, 1'b0, 1'b1};
      v[21] = '{32'h3FFFFFFF, 32'h33800000, 1'b0, 2'd1, 32'h40000000, 1'b0, 1'b0, 1'b0, 1'b1};
      v[22] = '{32'h7F800000, 32'h7F800000, 1'b1, 2'd0, 32'h7FC00000, 1'b0, 1'b0, 1'b1, 1'b0};
      v[23] = '{32'h3F800000, 32'h7F800000, 1'b1, 2'd0, 32'hFF800000, 1'b0, 1'b0, 1'b0, 1'b0};
      #12;
      chk("reset_in_ready", 32'(in_ready), 32'd0);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_result", final_result_ieee, 32'd0);
      chk("reset_flags", {29'd0, overflow_flag, underflow_flag, invalid_flag}, 32'd0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1 chk("in_ready_after_reset", 32'(in_ready), 32'd1);
      for (int i = 0; i < 24; i++) begin
         do_op(v[i].x, v[i].y, v[i].op, v[i].rm, lat);
         check_vec($sformatf("v%0d", i), v[i], lat);
         finish_op;
      end
      do_op(v[0].x, v[0].y, v[0].op, v[0].rm, lat);
      check_vec("hold", v[0], lat);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         chk("hold_out_valid", 32'(out_valid), 32'd1);
         chk("hold_result", final_result_ieee, 32'h40400000);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      finish_op;
      chk("in_ready_after_handshake", 32'(in_ready), 32'd1);
      @(negedge clk);
      Data_X = 32'h3F800000; Data_Y = 32'h40000000; add_subt = 1'b0; r_mode = 2'd0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      #2;
      chk("abort_in_ready", 32'(in_ready), 32'd0);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_result", final_result_ieee, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1 chk("abort_in_ready_first_edge", 32'(in_ready), 32'd1);
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk);
         #1 seen |= out_valid;
      end
      chk("abort_no_out_valid", 32'(seen), 32'd0);
      do_op(v[9].x, v[9].y, v[9].op, v[9].rm, lat);
      check_vec("after_abort", v[9], lat);
      finish_op;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
